// File: rtl/bp_be_pkg.sv
`default_nettype none
// ============================================================
// Package : bp_be_pkg
// Brief   : Shared types for the backend PTW arbiter.
// Revision: 1.0
// ============================================================
package bp_be_pkg;

    localparam int unsigned c_PTW_ARB_VADDR_W = 39;

    typedef enum logic [1:0] {
        eIdle  = 2'd0,
        eWalk  = 2'd1,
        eDrain = 2'd2
    } bp_be_ptw_arb_state_e;

    typedef enum logic {
        eSrcI = 1'b0,
        eSrcD = 1'b1
    } bp_be_ptw_arb_src_e;

    typedef struct packed {
        logic                         v;
        logic                         store;
        logic [c_PTW_ARB_VADDR_W-1:0] vaddr;
        logic [c_PTW_ARB_VADDR_W-1:0] pc;
    } bp_be_ptw_arb_slot_s;

endpackage
`default_nettype wire

// File: rtl/bp_be_ptw_arb_slot.sv
`default_nettype none
// ============================================================
// Module  : bp_be_ptw_arb_slot
// Brief   : One-entry pending-miss buffer; clear has priority.
// Revision: 1.0
// ============================================================
module bp_be_ptw_arb_slot
    import bp_be_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         clear_i,
    input  logic                         accept_i,
    input  logic [c_PTW_ARB_VADDR_W-1:0] vaddr_i,
    input  logic [c_PTW_ARB_VADDR_W-1:0] pc_i,
    input  logic                         store_i,
    output bp_be_ptw_arb_slot_s          slot_o
);

    bp_be_ptw_arb_slot_s slot_d, slot_q;

    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d.v = 1'b0;
        end else if (accept_i) begin
            slot_d.v     = 1'b1;
            slot_d.store = store_i;
            slot_d.vaddr = vaddr_i;
            slot_d.pc    = pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) slot_q <= '0;
        else            slot_q <= slot_d;
    end

    assign slot_o = slot_q;

endmodule
`default_nettype wire

// File: rtl/bp_be_ptw_arbiter.sv
`default_nettype none
// ============================================================
// Module  : bp_be_ptw_arbiter
// Brief   : Shares the backend PTW between ITLB and DTLB misses.
// Revision: 1.0
// ============================================================
module bp_be_ptw_arbiter
    import bp_be_pkg::*;
#(
    parameter int unsigned vaddr_width_p     = c_PTW_ARB_VADDR_W,
    parameter int unsigned tlb_entry_width_p = 34,
    parameter int unsigned timeout_cycles_p  = 256
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         flush_i,
    input  logic                         itlb_miss_v_i,
    output logic                         itlb_miss_ready_o,
    input  logic [vaddr_width_p-1:0]     itlb_miss_vaddr_i,
    input  logic [vaddr_width_p-1:0]     itlb_miss_pc_i,
    input  logic                         dtlb_miss_v_i,
    output logic                         dtlb_miss_ready_o,
    input  logic                         dtlb_miss_store_i,
    input  logic [vaddr_width_p-1:0]     dtlb_miss_vaddr_i,
    input  logic [vaddr_width_p-1:0]     dtlb_miss_pc_i,
    output logic                         ptw_miss_v_o,
    output logic                         ptw_miss_instr_v_o,
    output logic                         ptw_miss_load_v_o,
    output logic                         ptw_miss_store_v_o,
    output logic [vaddr_width_p-1:0]     ptw_miss_vaddr_o,
    output logic [vaddr_width_p-1:0]     ptw_miss_pc_o,
    input  logic                         ptw_busy_i,
    input  logic                         ptw_tlb_w_v_i,
    input  logic                         ptw_tlb_w_itlb_not_dtlb_i,
    input  logic [tlb_entry_width_p-1:0] ptw_tlb_w_entry_i,
    input  logic [vaddr_width_p-1:0]     ptw_tlb_w_vaddr_i,
    input  logic                         ptw_instr_pf_i,
    input  logic                         ptw_load_pf_i,
    input  logic                         ptw_store_pf_i,
    output logic                         itlb_fill_v_o,
    output logic                         dtlb_fill_v_o,
    output logic [tlb_entry_width_p-1:0] fill_entry_o,
    output logic [vaddr_width_p-1:0]     fill_vaddr_o,
    output logic                         instr_page_fault_o,
    output logic                         load_page_fault_o,
    output logic                         store_page_fault_o,
    output logic                         error_o
);

    localparam int unsigned     c_WD_W   = $clog2(timeout_cycles_p + 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(timeout_cycles_p);

    bp_be_ptw_arb_state_e state_d, state_q;
    bp_be_ptw_arb_src_e   owner_d, owner_q, last_grant_d, last_grant_q, sel;
    bp_be_ptw_arb_slot_s  islot, dslot;
    logic [c_WD_W-1:0]    wd_cnt_d, wd_cnt_q;
    logic                 error_d, error_q;
    logic                 grant, complete, err_set, iclear, dclear;
    logic                 unused_islot_store;

    assign unused_islot_store = islot.store;

    bp_be_ptw_arb_slot u_islot (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (iclear),
        .accept_i  (itlb_miss_v_i & ~islot.v & ~flush_i),
        .vaddr_i   (itlb_miss_vaddr_i),
        .pc_i      (itlb_miss_pc_i),
        .store_i   (1'b0),
        .slot_o    (islot)
    );

    bp_be_ptw_arb_slot u_dslot (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (dclear),
        .accept_i  (dtlb_miss_v_i & ~dslot.v & ~flush_i),
        .vaddr_i   (dtlb_miss_vaddr_i),
        .pc_i      (dtlb_miss_pc_i),
        .store_i   (dtlb_miss_store_i),
        .slot_o    (dslot)
    );

    assign itlb_miss_ready_o = ~islot.v;
    assign dtlb_miss_ready_o = ~dslot.v;
    assign fill_entry_o      = ptw_tlb_w_entry_i;
    assign fill_vaddr_o      = ptw_tlb_w_vaddr_i;
    assign complete          = ptw_tlb_w_v_i | ptw_instr_pf_i | ptw_load_pf_i | ptw_store_pf_i;
    assign ptw_miss_vaddr_o  = (sel == eSrcD) ? dslot.vaddr : islot.vaddr;
    assign ptw_miss_pc_o     = (sel == eSrcD) ? dslot.pc    : islot.pc;
    assign error_o           = error_q;

    always_comb begin
        // Round-robin on a tie: whoever was not granted last goes next
        if (islot.v & dslot.v) sel = (last_grant_q == eSrcI) ? eSrcD : eSrcI;
        else if (dslot.v)      sel = eSrcD;
        else                   sel = eSrcI;
    end

    always_comb begin
        state_d            = state_q;
        owner_d            = owner_q;
        last_grant_d       = last_grant_q;
        grant              = 1'b0;
        err_set            = 1'b0;
        iclear             = flush_i;
        dclear             = flush_i;
        itlb_fill_v_o      = 1'b0;
        dtlb_fill_v_o      = 1'b0;
        instr_page_fault_o = 1'b0;
        load_page_fault_o  = 1'b0;
        store_page_fault_o = 1'b0;
        case (state_q)
            eIdle: begin
                grant = ~ptw_busy_i & (islot.v | dslot.v) & ~flush_i;
                if (grant) begin
                    state_d      = eWalk;
                    owner_d      = sel;
                    last_grant_d = sel;
                end
            end
            eWalk: begin
                if (complete) begin
                    state_d = eIdle;
                    if (owner_q == eSrcI) iclear = 1'b1;
                    else                  dclear = 1'b1;
                    if (ptw_tlb_w_v_i) begin
                        if (ptw_tlb_w_itlb_not_dtlb_i == (owner_q == eSrcI)) begin
                            itlb_fill_v_o = (owner_q == eSrcI);
                            dtlb_fill_v_o = (owner_q == eSrcD);
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                    if (owner_q == eSrcI) begin
                        instr_page_fault_o = ptw_instr_pf_i;
                        if (ptw_load_pf_i | ptw_store_pf_i) err_set = 1'b1;
                    end else begin
                        load_page_fault_o  = ptw_load_pf_i;
                        store_page_fault_o = ptw_store_pf_i;
                    end
                end else if (flush_i) begin
                    state_d = eDrain;
                end
            end
            eDrain: begin
                if (!ptw_busy_i) state_d = eIdle;
            end
            default: state_d = eIdle;
        endcase
    end

    assign ptw_miss_v_o       = grant;
    assign ptw_miss_instr_v_o = grant & (sel == eSrcI);
    assign ptw_miss_load_v_o  = grant & (sel == eSrcD) & ~dslot.store;
    assign ptw_miss_store_v_o = grant & (sel == eSrcD) &  dslot.store;

    always_comb begin
        wd_cnt_d = '0;
        if (state_q != eIdle) begin
            wd_cnt_d = (wd_cnt_q == c_WD_MAX) ? wd_cnt_q : wd_cnt_q + c_WD_W'(1);
        end
        error_d = error_q | err_set | (wd_cnt_q == c_WD_MAX);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= eIdle;
            owner_q      <= eSrcI;
            last_grant_q <= eSrcI;
            wd_cnt_q     <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wd_cnt_q     <= wd_cnt_d;
            error_q      <= error_d;
        end
    end

endmodule
`default_nettype wire
